// File: rtl/tft_pkg.sv
// Shared display constants, grant encoding and writer round-robin pick for the TFT RAM arbiter.
package tft_pkg;

    localparam int H_VALID    = 800;
    localparam int V_VALID    = 480;
    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 24;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR0  = 2'd2,
        GNT_WR1  = 2'd3
    } gnt_e;

    // rr=0 favours wr0, rr=1 favours wr1; a lone requester always wins.
    function automatic gnt_e pick_wr(input logic [1:0] req, input logic rr);
        if (req[0] && (!req[1] || !rr)) return GNT_WR0;
        if (req[1]) return GNT_WR1;
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/tft_wait_cnt.sv
// Per-writer saturating wait counter; raises a sticky starve flag when the count reaches MAX_WAIT.
module tft_wait_cnt #(
    parameter logic [15:0] MAX_WAIT = 16'd2048
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic gnt,
    input  logic clr,
    output logic starve
);

    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        hit;

    always_comb begin
        cnt_nxt = 16'd0;
        if (req && !gnt)
            cnt_nxt = (cnt >= MAX_WAIT) ? MAX_WAIT : cnt + 16'd1;
    end

    // Only the transition onto MAX_WAIT counts, so a clear can stick while saturated.
    assign hit = req && !gnt && (cnt != MAX_WAIT) && (cnt_nxt == MAX_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 16'd0;
            starve <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (hit)
                starve <= 1'b1;
            else if (clr)
                starve <= 1'b0;
        end
    end

endmodule

// File: rtl/tft_ram_arb.sv
// Display RAM arbiter: pixel reads always win, writers share idle cycles round-robin.
// Define TFT_RAM_ARB_TEAR_FREE_EN to confine wr1 grants to the vertical blanking window.
module tft_ram_arb
    import tft_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          DATA_W   = DATA_W_DEF,
    parameter logic [15:0] MAX_WAIT = 16'd2048
) (
    input  logic              tft_clk_33m,
    input  logic              sys_rst_n,
    input  logic              vsync,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld,
    input  logic              wr0_req,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_gnt,
    input  logic              wr1_req,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_gnt,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        wr_starve
);

    localparam int NWR = 2;

    logic [NWR-1:0]             wr_req_raw;
    logic [NWR-1:0]             wr_req_arb;
    logic [NWR-1:0]             gnt;
    logic [NWR-1:0][ADDR_W-1:0] wr_addr;
    logic [NWR-1:0][DATA_W-1:0] wr_data;
    logic                       rr;
    logic                       vsync_q;
    logic                       vs_rise;
    logic [1:0]                 vld_pipe;
    gnt_e                       sel;

    assign wr_req_raw = {wr1_req, wr0_req};
    assign wr_addr    = {wr1_addr, wr0_addr};
    assign wr_data    = {wr1_data, wr0_data};
    assign vs_rise    = vsync & ~vsync_q;

`ifdef TFT_RAM_ARB_TEAR_FREE_EN
    logic rd_req_q;
    logic blank_win;

    always_ff @(posedge tft_clk_33m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_req_q  <= 1'b0;
            blank_win <= 1'b0;
        end else begin
            rd_req_q <= rd_req;
            if (vs_rise)
                blank_win <= 1'b1;
            else if (rd_req && !rd_req_q)
                blank_win <= 1'b0;
        end
    end

    // wr1 is invisible to arbitration outside blanking; its wait counter still sees the raw request.
    assign wr_req_arb = {wr1_req & blank_win, wr0_req};
`else
    assign wr_req_arb = wr_req_raw;
`endif

    // Decision is gated by reset so strobes and grants drop asynchronously.
    always_comb begin
        sel = GNT_NONE;
        if (sys_rst_n) begin
            if (rd_req)
                sel = GNT_RD;
            else
                sel = pick_wr(wr_req_arb, rr);
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        gnt       = '0;
        case (sel)
            GNT_RD: begin
                ram_en   = 1'b1;
                ram_addr = rd_addr;
            end
            GNT_WR0: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = wr_addr[0];
                ram_wdata = wr_data[0];
                gnt[0]    = 1'b1;
            end
            GNT_WR1: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = wr_addr[1];
                ram_wdata = wr_data[1];
                gnt[1]    = 1'b1;
            end
            default: ;
        endcase
    end

    assign wr0_gnt = gnt[0];
    assign wr1_gnt = gnt[1];

    assign vld_pipe[0] = rd_req;

    always_ff @(posedge tft_clk_33m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rr          <= 1'b0;
            vsync_q     <= 1'b0;
            vld_pipe[1] <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            vld_pipe[1] <= vld_pipe[0];
            if (gnt[0])
                rr <= 1'b1;
            else if (gnt[1])
                rr <= 1'b0;
        end
    end

    assign rd_vld  = vld_pipe[1];
    assign rd_data = rd_vld ? ram_rdata : '0;

    for (genvar i = 0; i < NWR; i++) begin : g_wait
        tft_wait_cnt #(
            .MAX_WAIT(MAX_WAIT)
        ) u_wait (
            .clk   (tft_clk_33m),
            .rst_n (sys_rst_n),
            .req   (wr_req_raw[i]),
            .gnt   (gnt[i]),
            .clr   (vs_rise),
            .starve(wr_starve[i])
        );
    end

endmodule

// File: tb/tb_tft_ram_arb.sv
// Bench for tft_ram_arb: table-driven arbitration vectors, read scoreboard, multi-cycle corner sequences.
module tb_tft_ram_arb;

    localparam int AW = 19;
    localparam int DW = 24;
`ifdef TFT_RAM_ARB_TEAR_FREE_EN
    localparam logic TF = 1'b1;
`else
    localparam logic TF = 1'b0;
`endif
    localparam logic [AW-1:0] A0 = 19'h00100;
    localparam logic [AW-1:0] A1 = 19'h00200;
    localparam logic [DW-1:0] D0 = 24'h0A0A0A;
    localparam logic [DW-1:0] D1 = 24'h0B0B0B;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_vld;
    logic          wr0_req = 1'b0, wr1_req = 1'b0;
    logic [AW-1:0] wr0_addr = '0, wr1_addr = '0;
    logic [DW-1:0] wr0_data = '0, wr1_data = '0;
    logic          wr0_gnt, wr1_gnt;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [1:0]    wr_starve;

    always #15 clk = ~clk;

    tft_ram_arb #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_WAIT(16'd16)
    ) dut (
        .tft_clk_33m(clk),
        .sys_rst_n  (rst_n),
        .vsync      (vsync),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_vld     (rd_vld),
        .wr0_req    (wr0_req),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr0_gnt    (wr0_gnt),
        .wr1_req    (wr1_req),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .wr1_gnt    (wr1_gnt),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .wr_starve  (wr_starve)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [DW-1:0] rdq[$];

    function automatic logic [DW-1:0] rdpat(input logic [AW-1:0] a);
        if (a == 19'h00010) return 24'hABCDEF;
        return {5'h0, a} ^ 24'hC35A96;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // RAM model with one-cycle read latency
    always @(posedge clk)
        ram_rdata <= (ram_en && !ram_we) ? rdpat(ram_addr) : '0;

    always @(negedge clk) begin
        #2;
        check("gnt_excl", 32'(wr0_gnt & wr1_gnt), 32'd0);
        if (rd_vld) begin
            if (rdq.size() == 0) check("rd_extra", 32'd1, 32'd0);
            else check("rd_data", 32'(rd_data), 32'(rdq.pop_front()));
        end
    end

    task automatic drive(input logic rd, input logic [AW-1:0] ra, input logic w0,
                         input logic w1, input logic vs);
        @(negedge clk);
        rd_req  = rd;
        rd_addr = rd ? ra : '0;
        wr0_req = w0;
        wr1_req = w1;
        vsync   = vs;
        if (rd) rdq.push_back(rdpat(ra));
        #1;
    endtask

    typedef struct packed {
        logic w0;
        logic w1;
        logic g0;
        logic g1;
    } vec_t;

    vec_t tv[12];

    initial begin
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        tv = '{4'b1110, 4'b1101, 4'b1110, 4'b1101, 4'b1110, 4'b1101,
               4'b0101, 4'b1010, 4'b1010, 4'b0000, 4'b1101, 4'b0000};
        wr0_addr = A0; wr0_data = D0;
        wr1_addr = A1; wr1_data = D1;

        repeat (2) @(negedge clk);
        #1;
        check("rst_en",     32'(ram_en),    32'd0);
        check("rst_we",     32'(ram_we),    32'd0);
        check("rst_addr",   32'(ram_addr),  32'd0);
        check("rst_wdata",  32'(ram_wdata), 32'd0);
        check("rst_rd_vld", 32'(rd_vld),    32'd0);
        check("rst_rd_dat", 32'(rd_data),   32'd0);
        check("rst_gnt",    32'({wr1_gnt, wr0_gnt}), 32'd0);
        check("rst_starve", 32'(wr_starve), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single read: strobes this cycle, data one cycle later
        drive(1'b1, 19'h00010, 1'b0, 1'b0, 1'b0);
        check("rd_en",   32'({ram_en, ram_we}), 32'b10);
        check("rd_addr", 32'(ram_addr), 32'h10);
        check("rd_vld0", 32'(rd_vld), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("rd_vld1", 32'(rd_vld), 32'd1);
        check("rd_dat1", 32'(rd_data), 32'hABCDEF);

        // open the blanking window before the writer table
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

        foreach (tv[i]) begin
            drive(1'b0, '0, tv[i].w0, tv[i].w1, 1'b0);
            ea = tv[i].g0 ? A0 : (tv[i].g1 ? A1 : '0);
            ed = tv[i].g0 ? D0 : (tv[i].g1 ? D1 : '0);
            check($sformatf("tv%0d_g0", i), 32'(wr0_gnt), 32'(tv[i].g0));
            check($sformatf("tv%0d_g1", i), 32'(wr1_gnt), 32'(tv[i].g1));
            check($sformatf("tv%0d_en", i), 32'({ram_en, ram_we}), 32'({2{tv[i].g0 | tv[i].g1}}));
            check($sformatf("tv%0d_addr", i), 32'(ram_addr), 32'(ea));
            check($sformatf("tv%0d_wdata", i), 32'(ram_wdata), 32'(ed));
        end

        // reads block wr0 for three cycles
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, AW'(k + 32), 1'b1, 1'b0, 1'b0);
            check("blk_g0", 32'(wr0_gnt), 32'd0);
            check("blk_en", 32'({ram_en, ram_we}), 32'b10);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("blk_g0_rel", 32'(wr0_gnt), 32'd1);
        check("blk_we",     32'(ram_we), 32'd1);
        check("blk_addr",   32'(ram_addr), 32'(A0));
        check("blk_wdata",  32'(ram_wdata), 32'(D0));
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("blk_g0_end", 32'(wr0_gnt), 32'd0);

        // wr1 starves behind 20 reads; flag rises once 16 waits have accumulated
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, AW'(k + 64), 1'b0, 1'b1, 1'b0);
            check($sformatf("starve_k%0d", k), 32'(wr_starve), (k > 16) ? 32'b10 : 32'b00);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("starve_g1",   32'(wr1_gnt), 32'(!TF));
        check("starve_held", 32'(wr_starve), 32'b10);
        drive(1'b0, '0, 1'b0, TF, 1'b1);
        check("starve_g1b",  32'(wr1_gnt), 32'(TF));
        check("starve_clr",  32'(wr_starve), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // starve event and vsync clear on the same edge: flag must stay set
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, AW'(k + 128), 1'b1, 1'b0, k == 16);
            check("race_pre", 32'(wr_starve[0]), 32'd0);
        end
        drive(1'b1, 19'h000C8, 1'b1, 1'b0, 1'b1);
        check("race_win", 32'(wr_starve[0]), 32'd1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("race_g0", 32'(wr0_gnt), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("race_sticky", 32'(wr_starve[0]), 32'd1);

        // wr1 across active reads and gaps, then a blanking interval
        drive(1'b1, 19'h00300, 1'b0, 1'b1, 1'b0);
        check("tf_c1", 32'(wr1_gnt), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("tf_c2", 32'(wr1_gnt), 32'(!TF));
        drive(1'b1, 19'h00301, 1'b0, 1'b1, 1'b0);
        check("tf_c3", 32'(wr1_gnt), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("tf_c4", 32'(wr1_gnt), 32'(!TF));
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("tf_c5", 32'(wr1_gnt), 32'(!TF));
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("tf_c6", 32'(wr1_gnt), 32'd1);
        check("tf_c6_addr", 32'(ram_addr), 32'(A1));
        check("tf_c6_starve", 32'(wr_starve), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("tf_c7", 32'(wr1_gnt), 32'd0);
        drive(1'b1, 19'h00302, 1'b0, 1'b1, 1'b0);
        check("tf_c8", 32'(wr1_gnt), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("tf_c9", 32'(wr1_gnt), 32'(!TF));
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // reset lands while a wr0 grant and a read return are live
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("rr_prep_g0", 32'(wr0_gnt), 32'd1);
        drive(1'b1, 19'h003A0, 1'b1, 1'b0, 1'b0);
        check("mid_rd_g0", 32'(wr0_gnt), 32'd0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("mid_g0",  32'(wr0_gnt), 32'd1);
        check("mid_vld", 32'(rd_vld), 32'd1);
        #4;
        rst_n = 1'b0;
        #1;
        check("arst_g0",  32'(wr0_gnt), 32'd0);
        check("arst_en",  32'({ram_en, ram_we}), 32'd0);
        check("arst_vld", 32'(rd_vld), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        wr0_req = 1'b1;
        wr1_req = 1'b1;
        #1;
        check("post_rst_g0", 32'(wr0_gnt), 32'd1);
        check("post_rst_g1", 32'(wr1_gnt), 32'd0);
        check("post_rst_starve", 32'(wr_starve), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("rdq_drained", 32'(rdq.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
